// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared types and default sizes for the FIFO write arbiter.
//   state_t    - arbiter FSM states (IDLE, G0, G1)
//   DEF_*      - default DATA_W, DEPTH and CNT_W
//   BEAT_W     - beat counter width, covers BURST_MAX up to 15
package fifo_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, G0, G1} state_t;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 64;
   localparam int DEF_CNT_W  = 7;
   localparam int BEAT_W     = 4;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer handshake and FIFO write bus.
//   req0/req1, data0/data1 - producer requests and words
//   gnt0/gnt1              - per-producer grants
//   wr_en, buf_in          - registered FIFO write strobe and data
//   buf_full, fifo_counter - FIFO status
//   slave: arbiter side, master: producer/FIFO side
interface fifo_wr_arbiter_if
   import fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
);
   logic              req0, req1;
   logic [DATA_W-1:0] data0, data1;
   logic              gnt0, gnt1;
   logic              wr_en;
   logic [DATA_W-1:0] buf_in;
   logic              buf_full;
   logic [CNT_W-1:0]  fifo_counter;
   modport slave (
      input  req0, req1, data0, data1, buf_full, fifo_counter,
      output gnt0, gnt1, wr_en, buf_in
   );
   modport master (
      output req0, req1, data0, data1, buf_full, fifo_counter,
      input  gnt0, gnt1, wr_en, buf_in
   );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin choice.
//   req0, req1 - requests
//   last       - producer granted most recently
//   vld        - at least one request
//   win        - chosen producer (the one not granted last on a tie)
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic vld,
   output logic win
);
   assign vld = req0 || req1;
   assign win = (req0 && req1) ? !last : req1;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst round-robin arbiter writing two producers into one FIFO.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - producer handshake, FIFO write port and FIFO status (slave side)
module fifo_wr_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int BURST_MAX = 4
)(
   input logic clk,
   input logic rst_n,
   fifo_wr_arbiter_if.slave bus
);
   state_t            state, state_n;
   logic              last, last_n;
   logic [BEAT_W-1:0] beat, beat_n;
   logic [CNT_W:0]    occ;
   logic [DATA_W-1:0] wdata;
   logic              space, cur, req_i, req_o, xfer, leave, pick_vld, pick_win;
   // occupancy counts the write still in flight, since fifo_counter lags wr_en by one edge
   assign occ   = {1'b0, bus.fifo_counter} + {{CNT_W{1'b0}}, bus.wr_en};
   assign space = !bus.buf_full && (occ < (CNT_W+1)'(DEPTH));
   assign bus.gnt0 = (state == G0) && space;
   assign bus.gnt1 = (state == G1) && space;
   assign cur   = (state == G1);
   assign req_i = cur ? bus.req1 : bus.req0;
   assign req_o = cur ? bus.req0 : bus.req1;
   assign xfer  = (bus.req0 && bus.gnt0) || (bus.req1 && bus.gnt1);
   assign wdata = cur ? bus.data1 : bus.data0;
   // a stalled grant (no space) freezes state, beat and last
   assign leave = space && (!req_i || (beat + 1'b1 == BEAT_W'(BURST_MAX)));
   rr_pick2 u_pick (
      .req0 (bus.req0),
      .req1 (bus.req1),
      .last (last),
      .vld  (pick_vld),
      .win  (pick_win)
   );
   always_comb begin
      state_n = state;
      last_n  = last;
      beat_n  = beat;
      if (state == IDLE) begin
         state_n = pick_vld ? (pick_win ? G1 : G0) : IDLE;
         beat_n  = '0;
      end else if (leave) begin
         last_n  = cur;
         beat_n  = '0;
         state_n = req_o ? (cur ? G0 : G1) : (req_i ? state : IDLE);
      end else if (xfer) begin
         beat_n  = beat + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last       <= 1'b1;
         beat       <= '0;
         bus.wr_en  <= 1'b0;
         bus.buf_in <= '0;
      end else begin
         state      <= state_n;
         last       <= last_n;
         beat       <= beat_n;
         bus.wr_en  <= xfer;
         bus.buf_in <= xfer ? wdata : '0;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;
   import fifo_ctrl_pkg::*;
   localparam int DW = 8, DEPTH = 64, CW = 7, BM = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   fifo_wr_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
   fifo_wr_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .BURST_MAX(BM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   int n_cmp = 0, n_err = 0, cyc = 0;
   logic [DW-1:0] p0[$], p1[$], exp_q[$];
   int acc_q[$];
   bit en0, en1, fifo_on;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask
   task automatic drive();
      bus.req0  = en0 && p0.size() != 0;
      bus.data0 = p0.size() != 0 ? p0[0] : '0;
      bus.req1  = en1 && p1.size() != 0;
      bus.data1 = p1.size() != 0 ? p1[0] : '0;
   endtask
   // one clock: check at the falling edge, then advance producers and the FIFO model
   task automatic tick();
      bit a0, a1, w;
      @(negedge clk);
      cyc++;
      a0 = bus.req0 && bus.gnt0;
      a1 = bus.req1 && bus.gnt1;
      w  = bus.wr_en;
      chk("gnt_excl", 32'(bus.gnt0 && bus.gnt1), 0);
      if (bus.buf_full || 32'(bus.fifo_counter) + 32'(bus.wr_en) >= DEPTH)
         chk("gnt_no_space", 32'({bus.gnt0, bus.gnt1}), 0);
      if (w) begin
         chk("fifo_ovf", 32'(32'(bus.fifo_counter) >= DEPTH), 0);
         if (exp_q.size() == 0) chk("spurious_wr", 32'(w), 0);
         else chk("wdata", 32'(bus.buf_in), 32'(exp_q.pop_front()));
         if (acc_q.size() != 0) chk("latency", 32'(cyc - acc_q.pop_front()), 1);
      end
      if (a0 || a1) acc_q.push_back(cyc);
      @(posedge clk);
      #1;
      if (a0) void'(p0.pop_front());
      if (a1) void'(p1.pop_front());
      if (fifo_on && w) bus.fifo_counter = bus.fifo_counter + 1'b1;
      drive();
   endtask
   task automatic apply_reset();
      rst_n = 1'b0;
      exp_q.delete();
      acc_q.delete();
      bus.buf_full = 1'b0;
      bus.fifo_counter = '0;
      fifo_on = 1'b0;
      en0 = 1'b1;
      en1 = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_en", 32'(bus.wr_en), 0);
      chk("rst_buf_in", 32'(bus.buf_in), 0);
      chk("rst_gnt", 32'({bus.gnt0, bus.gnt1}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_gnt", 32'({bus.gnt0, bus.gnt1}), 0);
   endtask
   initial begin
      p0 = '{8'h32, 8'h1D, 8'h3D};
      p1.delete();
      apply_reset();
      exp_q = '{8'h32, 8'h1D, 8'h3D};
      repeat (8) tick();
      chk("drain_single", 32'(exp_q.size()), 0);
      p0.delete();
      p1.delete();
      for (int k = 0; k < 12; k++) begin
         p0.push_back(8'(k + 1));
         p1.push_back(8'(8'h80 + k));
      end
      apply_reset();
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < BM; k++) exp_q.push_back(8'(b * BM + k + 1));
         for (int k = 0; k < BM; k++) exp_q.push_back(8'(8'h80 + b * BM + k));
      end
      repeat (40) tick();
      chk("drain_contention", 32'(exp_q.size()), 0);
      p0 = '{8'hA1, 8'hA2, 8'hA3};
      p1.delete();
      apply_reset();
      bus.fifo_counter = 7'd62;
      fifo_on = 1'b1;
      exp_q = '{8'hA1, 8'hA2, 8'hA3};
      repeat (5) tick();
      chk("bp_stall_gnt", 32'(bus.gnt0), 0);
      chk("bp_stall_cnt", 32'(bus.fifo_counter), 64);
      bus.fifo_counter = 7'd62;
      #1;
      chk("bp_resume_gnt", 32'(bus.gnt0), 1);
      repeat (6) tick();
      chk("drain_bp", 32'(exp_q.size()), 0);
      p0 = '{8'hA0, 8'hA1};
      p1.delete();
      for (int k = 0; k < 6; k++) p1.push_back(8'(8'hB0 + k));
      apply_reset();
      en0 = 1'b0;
      drive();
      exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA0, 8'hA1, 8'hB4, 8'hB5};
      repeat (2) tick();
      bus.buf_full = 1'b1;
      en0 = 1'b1;
      drive();
      repeat (3) tick();
      chk("full_gnt1", 32'(bus.gnt1), 0);
      chk("full_wr_en", 32'(bus.wr_en), 0);
      bus.buf_full = 1'b0;
      #1;
      chk("full_resume_gnt1", 32'(bus.gnt1), 1);
      repeat (14) tick();
      chk("drain_full", 32'(exp_q.size()), 0);
      p1.delete();
      p0.delete();
      for (int k = 0; k < 6; k++) p0.push_back(8'(8'hC0 + k));
      apply_reset();
      exp_q = '{8'hC0};
      repeat (2) tick();
      chk("pre_rst_wr_en", 32'(bus.wr_en), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr_en", 32'(bus.wr_en), 0);
      chk("mid_rst_buf_in", 32'(bus.buf_in), 0);
      chk("mid_rst_gnt0", 32'(bus.gnt0), 0);
      chk("drain_mid_rst", 32'(exp_q.size()), 0);
      p0 = '{8'hD0, 8'hD1};
      p1 = '{8'hE0, 8'hE1};
      apply_reset();
      exp_q = '{8'hD0, 8'hD1, 8'hE0, 8'hE1};
      repeat (10) tick();
      chk("drain_after_rst", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
